// File: rtl/xbox_xlr_dmy1.sv
// Dummy accelerator: streams memory 0, adds a host constant per word, writes memory 1, reports word sum.
// Optional cycle counter reported in host register 1 when XLR_DMY1_CYCLE_CNT_EN is defined.
module xbox_xlr_dmy1 #(
    parameter int unsigned NUM_MEMS           = 2,
    parameter int unsigned LOG2_LINES_PER_MEM = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]  xlr_mem_addr,
    output logic [NUM_MEMS-1:0][255:0]                   xlr_mem_wdata,
    output logic [NUM_MEMS-1:0][31:0]                    xlr_mem_be,
    output logic [NUM_MEMS-1:0]                          xlr_mem_rd,
    output logic [NUM_MEMS-1:0]                          xlr_mem_wr,
    input  logic [NUM_MEMS-1:0][255:0]                   xlr_mem_rdata,
    input  logic [31:0][31:0]                            host_regs,
    input  logic                                         host_regs_valid_pulse,
    output logic [31:0][31:0]                            host_regs_data_out,
    output logic [31:0]                                  host_regs_valid_out
);

    localparam int unsigned AW     = LOG2_LINES_PER_MEM;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WORDS  = 8;
    localparam int unsigned LINE_W = WORD_W * WORDS;
    localparam logic [AW-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t              state, state_n;
    logic [AW-1:0]       idx, idx_n;
    logic [WORD_W-1:0]   sum, sum_n;
    logic [WORD_W-1:0]   add, add_n;
    logic [LINE_W-1:0]   line, line_n;
    logic [WORD_W-1:0]   line_sum_c;
    logic [LINE_W-1:0]   rdata_plus_c;
    logic                start_c;

    logic [NUM_MEMS-1:0][AW-1:0]     addr_n;
    logic [NUM_MEMS-1:0][LINE_W-1:0] wdata_n;
    logic [NUM_MEMS-1:0][31:0]       be_n;
    logic [NUM_MEMS-1:0]             rd_n, wr_n;
    logic [31:0][31:0]               data_out_n;
    logic [31:0]                     valid_n;

    logic unused_ok;
    assign unused_ok = ^{host_regs[31:2], host_regs[0][31:1], xlr_mem_rdata[NUM_MEMS-1:1]};

    assign start_c = host_regs_valid_pulse && host_regs[0][0];

    // Per-word arithmetic on the held line and on the line arriving from memory 0
    always_comb begin
        line_sum_c   = '0;
        rdata_plus_c = '0;
        for (int w = 0; w < int'(WORDS); w++) begin
            line_sum_c = line_sum_c + line[WORD_W*w +: WORD_W];
            rdata_plus_c[WORD_W*w +: WORD_W] = xlr_mem_rdata[0][WORD_W*w +: WORD_W] + add;
        end
    end

`ifdef XLR_DMY1_CYCLE_CNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt <= '0;
        end else if (state == IDLE && start_c) begin
            cnt <= '0;
        end else if (state == READ || state == WAIT || state == WRITE) begin
            cnt <= cnt + 32'd1;
        end
    end
`endif

    // Next state plus next registered outputs, so strobes line up with the state they belong to
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        sum_n      = sum;
        add_n      = add;
        line_n     = line;
        addr_n     = '0;
        wdata_n    = '0;
        be_n       = '0;
        rd_n       = '0;
        wr_n       = '0;
        data_out_n = host_regs_data_out;
        valid_n    = '0;

        case (state)
            IDLE: begin
                if (start_c) begin
                    state_n   = READ;
                    add_n     = host_regs[1];
                    idx_n     = '0;
                    sum_n     = '0;
                    rd_n[0]   = 1'b1;
                    addr_n[0] = '0;
                end
            end
            READ: begin
                state_n = WAIT;
            end
            WAIT: begin
                state_n    = WRITE;
                line_n     = xlr_mem_rdata[0];
                wr_n[1]    = 1'b1;
                addr_n[1]  = idx;
                be_n[1]    = '1;
                wdata_n[1] = rdata_plus_c;
            end
            WRITE: begin
                sum_n = sum + line_sum_c;
                if (idx == LAST_IDX) begin
                    state_n       = DONE;
                    data_out_n[0] = sum_n;
                    data_out_n[2] = add;
                    valid_n[0]    = 1'b1;
                    valid_n[2]    = 1'b1;
`ifdef XLR_DMY1_CYCLE_CNT_EN
                    data_out_n[1] = cnt + 32'd1;
                    valid_n[1]    = 1'b1;
`endif
                end else begin
                    state_n   = READ;
                    idx_n     = idx + AW'(1);
                    rd_n[0]   = 1'b1;
                    addr_n[0] = idx_n;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state               <= IDLE;
            idx                 <= '0;
            sum                 <= '0;
            add                 <= '0;
            line                <= '0;
            xlr_mem_addr        <= '0;
            xlr_mem_wdata       <= '0;
            xlr_mem_be          <= '0;
            xlr_mem_rd          <= '0;
            xlr_mem_wr          <= '0;
            host_regs_data_out  <= '0;
            host_regs_valid_out <= '0;
        end else begin
            state               <= state_n;
            idx                 <= idx_n;
            sum                 <= sum_n;
            add                 <= add_n;
            line                <= line_n;
            xlr_mem_addr        <= addr_n;
            xlr_mem_wdata       <= wdata_n;
            xlr_mem_be          <= be_n;
            xlr_mem_rd          <= rd_n;
            xlr_mem_wr          <= wr_n;
            host_regs_data_out  <= data_out_n;
            host_regs_valid_out <= valid_n;
        end
    end

endmodule

// File: tb/tb_xbox_xlr_dmy1.sv
// Self-checking bench for xbox_xlr_dmy1: table-driven passes plus ignored-start and mid-run reset sequences.
module tb_xbox_xlr_dmy1;

    localparam int unsigned NM = 3;
    localparam int unsigned AW = 4;
    localparam int L = 16;
`ifdef XLR_DMY1_CYCLE_CNT_EN
    localparam logic [31:0] VMASK   = 32'h7;
    localparam logic [31:0] EXP_CNT = 32'd48;
`else
    localparam logic [31:0] VMASK   = 32'h5;
    localparam logic [31:0] EXP_CNT = 32'd0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NM-1:0][AW-1:0]      xlr_mem_addr;
    logic [NM-1:0][255:0]       xlr_mem_wdata;
    logic [NM-1:0][31:0]        xlr_mem_be;
    logic [NM-1:0]              xlr_mem_rd;
    logic [NM-1:0]              xlr_mem_wr;
    logic [NM-1:0][255:0]       xlr_mem_rdata;
    logic [31:0][31:0]          host_regs;
    logic                       host_regs_valid_pulse;
    logic [31:0][31:0]          host_regs_data_out;
    logic [31:0]                host_regs_valid_out;

    xbox_xlr_dmy1 #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(AW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .xlr_mem_addr          (xlr_mem_addr),
        .xlr_mem_wdata         (xlr_mem_wdata),
        .xlr_mem_be            (xlr_mem_be),
        .xlr_mem_rd            (xlr_mem_rd),
        .xlr_mem_wr            (xlr_mem_wr),
        .xlr_mem_rdata         (xlr_mem_rdata),
        .host_regs             (host_regs),
        .host_regs_valid_pulse (host_regs_valid_pulse),
        .host_regs_data_out    (host_regs_data_out),
        .host_regs_valid_out   (host_regs_valid_out)
    );

    always #5 clk = ~clk;

    logic [255:0] mem0 [L];
    logic [255:0] mem1 [L];

    // Memory models: one-cycle read latency on port 0, byte-enabled writes on port 1
    always @(posedge clk) begin
        if (xlr_mem_rd[0]) xlr_mem_rdata[0] <= mem0[xlr_mem_addr[0]];
        if (xlr_mem_wr[1]) begin
            for (int b = 0; b < 32; b++)
                if (xlr_mem_be[1][b]) mem1[xlr_mem_addr[1]][8*b +: 8] <= xlr_mem_wdata[1][8*b +: 8];
        end
    end
    initial begin
        xlr_mem_rdata[1] = '0;
        xlr_mem_rdata[2] = '0;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat_word(input int pat, input int i, input int w);
        case (pat)
            0:       return 32'(8*i + w);
            1:       return 32'h0;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic fill_mems(input int pat);
        for (int i = 0; i < L; i++)
            for (int w = 0; w < 8; w++) begin
                mem0[i][32*w +: 32] = pat_word(pat, i, w);
                mem1[i][32*w +: 32] = 32'hA5A5_A5A5;
            end
    endtask

    task automatic pulse_start(input logic [31:0] r0, input logic [31:0] r1);
        @(posedge clk);
        #1;
        host_regs[0] = r0;
        host_regs[1] = r1;
        host_regs_valid_pulse = 1'b1;
        @(posedge clk);
        #1;
        host_regs_valid_pulse = 1'b0;
        host_regs = '0;
    endtask

    // Watch cycles 1..ncyc after the start edge against the expected schedule
    task automatic observe(input bit active, input int ncyc, input int mid_cyc, input int rst_cyc,
                           output int sched_err, output int excl_err, output int done_cyc);
        bit run;
        bit erd, ewr;
        logic [31:0] ev;
        sched_err = 0;
        excl_err  = 0;
        done_cyc  = -1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            run = active && (rst_cyc == 0 || c <= rst_cyc);
            erd = run && c <= 3*L && (c % 3 == 1);
            ewr = run && c <= 3*L && (c % 3 == 0);
            ev  = (run && c == 3*L+1) ? VMASK : 32'h0;
            if (xlr_mem_rd[0] !== erd || xlr_mem_wr[1] !== ewr) sched_err++;
            if (xlr_mem_addr[0] !== (erd ? AW'((c-1)/3) : AW'(0))) sched_err++;
            if (xlr_mem_addr[1] !== (ewr ? AW'((c-3)/3) : AW'(0))) sched_err++;
            if (xlr_mem_be[1] !== (ewr ? 32'hFFFF_FFFF : 32'h0)) sched_err++;
            if (host_regs_valid_out !== ev) sched_err++;
            if (host_regs_valid_out[0] === 1'b1) done_cyc = c;
            if ((xlr_mem_rd[0] && xlr_mem_wr[1]) || xlr_mem_rd[1] || xlr_mem_wr[0] ||
                xlr_mem_rd[2] || xlr_mem_wr[2] || (|xlr_mem_be[0]) || (|xlr_mem_be[2]) ||
                (|xlr_mem_wdata[0]) || (|xlr_mem_wdata[2]) || (|xlr_mem_addr[2]))
                excl_err++;
            host_regs_valid_pulse = 1'b0;
            rst_n = 1'b0;
            if (c == mid_cyc) begin
                host_regs[0] = 32'h1;
                host_regs[1] = 32'h7;
                host_regs_valid_pulse = 1'b1;
            end
            if (c == rst_cyc) rst_n = 1'b1;
        end
        host_regs = '0;
    endtask

    typedef struct {
        int          pat;
        logic [31:0] add;
        int          mid;
        logic [31:0] exp_sum;
    } vec_t;

    task automatic run_pass(input string tag, input vec_t v);
        int se, xe, dc, bad;
        logic [31:0] exp;
        fill_mems(v.pat);
        pulse_start(32'h1, v.add);
        observe(1'b1, 55, v.mid, 0, se, xe, dc);
        check({tag, "_sched"}, 32'(se), 32'd0);
        check({tag, "_excl"}, 32'(xe), 32'd0);
        check({tag, "_done_cyc"}, 32'(dc), 32'd49);
        check({tag, "_sum"}, host_regs_data_out[0], v.exp_sum);
        check({tag, "_add"}, host_regs_data_out[2], v.add);
        check({tag, "_cnt"}, host_regs_data_out[1], EXP_CNT);
        check({tag, "_unused_out"}, 32'(|host_regs_data_out[31:3]), 32'd0);
        bad = 0;
        for (int i = 0; i < L; i++)
            for (int w = 0; w < 8; w++) begin
                exp = pat_word(v.pat, i, w) + v.add;
                if (mem1[i][32*w +: 32] !== exp) bad++;
            end
        check({tag, "_mem1_words"}, 32'(bad), 32'd0);
    endtask

    vec_t vecs [4];

    initial begin
        int se, xe, dc;
        logic [31:0] wv;

        vecs[0] = '{pat: 0, add: 32'h1,         mid: 10, exp_sum: 32'd8128};
        vecs[1] = '{pat: 0, add: 32'hFFFF_FFFF, mid: 0,  exp_sum: 32'd8128};
        vecs[2] = '{pat: 1, add: 32'h1234_5678, mid: 0,  exp_sum: 32'd0};
        vecs[3] = '{pat: 2, add: 32'h2,         mid: 0,  exp_sum: 32'hFFFF_FF80};

        host_regs = '0;
        host_regs_valid_pulse = 1'b0;
        rst_n = 1'b1;
        fill_mems(0);

        // Reset held for three cycles, then idle after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd", 32'(xlr_mem_rd), 32'd0);
        check("rst_wr", 32'(xlr_mem_wr), 32'd0);
        check("rst_addr_be_wdata", 32'(|{xlr_mem_addr, xlr_mem_be, xlr_mem_wdata}), 32'd0);
        check("rst_data_out", 32'(|host_regs_data_out), 32'd0);
        check("rst_valid_out", host_regs_valid_out, 32'd0);
        rst_n = 1'b0;
        observe(1'b0, 4, 0, 0, se, xe, dc);
        check("post_rst_idle", 32'(se + xe), 32'd0);

        // Start pulse without bit 0 is ignored
        pulse_start(32'h2, 32'h5);
        observe(1'b0, 12, 0, 0, se, xe, dc);
        check("ignored_start_access", 32'(se + xe), 32'd0);
        check("ignored_start_done", 32'(dc), 32'hFFFF_FFFF);

        for (int k = 0; k < 4; k++) begin
            run_pass($sformatf("vec%0d", k), vecs[k]);
            if (k == 1) begin
                wv = mem1[0][31:0];
                check("wrap_l0_w0", wv, 32'hFFFF_FFFF);
                wv = mem1[0][63:32];
                check("wrap_l0_w1", wv, 32'h0);
                wv = mem1[15][255:224];
                check("wrap_l15_w7", wv, 32'd126);
            end
        end

        // Reset in the middle of a pass aborts it silently
        fill_mems(0);
        pulse_start(32'h1, 32'h9);
        observe(1'b1, 55, 0, 20, se, xe, dc);
        check("midrst_sched", 32'(se + xe), 32'd0);
        check("midrst_no_done", 32'(dc), 32'hFFFF_FFFF);
        check("midrst_data_out", host_regs_data_out[0], 32'd0);
        wv = mem1[15][31:0];
        check("midrst_no_late_write", wv, 32'hA5A5_A5A5);
        run_pass("after_rst", '{pat: 0, add: 32'h3, mid: 0, exp_sum: 32'd8128});

        // Back-to-back restart right after DONE
        fill_mems(1);
        @(posedge clk);
        #1;
        host_regs[0] = 32'h1;
        host_regs[1] = 32'h4;
        host_regs_valid_pulse = 1'b1;
        @(posedge clk);
        #1;
        host_regs_valid_pulse = 1'b0;
        host_regs = '0;
        observe(1'b1, 50, 0, 0, se, xe, dc);
        check("restart_sched", 32'(se + xe), 32'd0);
        check("restart_add", host_regs_data_out[2], 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/xbox_xlr_dmy1.md
# xbox_xlr_dmy1

Dummy accelerator for the xbox accelerator slot. The host starts it through the general-purpose host register bank. It then streams every line of memory 0, adds a host-supplied constant to each 32-bit word, and writes the result to the same line of memory 1. When the pass is complete it reports the sum of all source words back to the host. It sits between the host register block (gpp interface) and the accelerator memory ports (mem interface).

## Interface
Parameters:
- NUM_MEMS, 2, number of memory ports; must be ≥2; only ports 0 and 1 are used.
- LOG2_LINES_PER_MEM, 4, address width per port; L = 2^LOG2_LINES_PER_MEM lines.
- Fixed constants: line width 256 bits (8 × 32-bit words, word w = bits [32w+31:32w]); 32 byte enables; 32 host registers of 32 bits.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-high reset (asserted = 1), sampled on clk.
- xlr_mem_addr  out  NUM_MEMS×LOG2_LINES_PER_MEM  line address per port.
- xlr_mem_wdata  out  NUM_MEMS×256  write data per port.
- xlr_mem_be  out  NUM_MEMS×32  byte enables per port.
- xlr_mem_rd  out  NUM_MEMS  read strobe per port.
- xlr_mem_wr  out  NUM_MEMS  write strobe per port.
- xlr_mem_rdata  in  NUM_MEMS×256  read data; valid the cycle after rd.
- host_regs  in  32×32  host register values.
- host_regs_valid_pulse  in  1  one-cycle strobe; host_regs are valid in that cycle.
- host_regs_data_out  out  32×32  result registers to the host.
- host_regs_valid_out  out  32  per-register write strobe to the host.

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- **IDLE → READ:** occurs when host_regs_valid_pulse=1 and host_regs[0][0]=1.
  - host_regs[1] is captured as ADD.
  - Line index i and SUM are cleared.
  - A pulse with bit0=0 is ignored.
  - Pulses in any state other than IDLE are ignored.
- **READ:**
  - xlr_mem_rd[0]=1, xlr_mem_addr[0]=i, for one cycle.
  - Goes to WAIT.
- **WAIT:**
  - xlr_mem_rdata[0] is registered as LINE.
  - Goes to WRITE.
- **WRITE:**
  - xlr_mem_wr[1]=1, xlr_mem_addr[1]=i, xlr_mem_be[1]=all ones.
  - wdata[1] word w = LINE word w + ADD, mod 2^32.
  - SUM += sum of the 8 LINE words, mod 2^32.
  - If i=L-1, goes to DONE. Otherwise i increments and the block goes to READ.
- **DONE:**
  - Loads host_regs_data_out[0]=SUM (with the final line included) and host_regs_data_out[2]=ADD.
  - host_regs_valid_out[0] and host_regs_valid_out[2] are 1 for exactly one cycle.
  - Goes to IDLE.
  - host_regs_data_out holds its values until the next DONE.
- Strobes and fields outside the active access are 0: rd, wr, addr, wdata and be on every port.
- Ports ≥2 are never driven active.
- Unused host_regs_data_out entries and unused valid bits are always 0.

## Timing
- **Reset:** while rst_n=1 on a clk edge:
  - State becomes IDLE.
  - i, SUM, ADD, LINE and the cycle counter become 0.
  - All outputs become 0.
- **Reset mid-run:** aborts the pass. No further rd or wr is issued, and no valid_out pulse occurs.
- **Schedule:** let the start pulse be sampled at edge 0.
  - Line i: READ in cycle 1+3i, WAIT in 2+3i, WRITE in 3+3i.
  - DONE in cycle 3L+1, which is cycle 49 for L=16.
- **Restart:** a new start is accepted in the cycle after DONE.
- Memory read latency is exactly 1 cycle. No backpressure exists.

## Configuration
- XLR_DMY1_CYCLE_CNT_EN defined:
  - A 32-bit counter counts cycles spent in READ, WAIT and WRITE during the pass, giving 3L.
  - In DONE it is written to host_regs_data_out[1] with host_regs_valid_out[1]=1.
- XLR_DMY1_CYCLE_CNT_EN undefined:
  - No counter exists.
  - host_regs_data_out[1] and host_regs_valid_out[1] are constant 0.

## Test plan
- **Reset:** hold rst_n=1 for 3 cycles → all outputs 0 and no strobes. Release → still idle with no strobes.
- **Basic pass:**
  - Stimulus: mem0 line i word w = 8i+w; start with host_regs[0]=1, host_regs[1]=1.
  - mem1 line i word w = 8i+w+1, all be set.
  - host_regs_data_out[0]=8128 and [2]=1.
  - valid_out[0] and valid_out[2] pulse exactly at cycle 49.
  - With the macro: data_out[1]=48.
- **Wrap:** ADD=0xFFFFFFFF, mem0 word 0 of line 0 = 0 → mem1 word 0 = 0xFFFFFFFF. Every other word is decremented by 1.
- **Ignored starts:**
  - A pulse with host_regs[0]=0 → no memory access.
  - A second start pulse at cycle 10 of a run → the schedule is unchanged and there is a single DONE.
- **Reset mid-run:** rst_n=1 at cycle 20 → no rd/wr afterward and no valid_out. A subsequent start completes a full pass correctly.
- **Strobe exclusivity:** throughout a pass, rd[0] and wr[1] are never high in the same cycle. rd[1], wr[0] and all strobes of ports ≥2 stay 0.
